// File: rtl/fcn_matrix_mult_pkg.sv
// Shared defaults for the fully-connected layer core.
// Sizes match the detection head's final flatten stage.
package fcn_matrix_mult_pkg;
    localparam int FCN_M  = 2;
    localparam int FCN_N  = 3;
    localparam int FCN_DW = 8;
    localparam int FCN_AW = 16;
endpackage

// File: rtl/fcn_dot_product.sv
// One output neuron: bias plus N signed products, wrapping to ACC_WIDTH.
// Purely combinational; the top level registers the result.
module fcn_dot_product
    import fcn_matrix_mult_pkg::*;
#(
    parameter int N          = FCN_N,
    parameter int DATA_WIDTH = FCN_DW,
    parameter int ACC_WIDTH  = FCN_AW
) (
    input  logic [DATA_WIDTH*N-1:0] w_row_i,
    input  logic [DATA_WIDTH*N-1:0] x_vec_i,
    input  logic [ACC_WIDTH-1:0]    bias_i,
    output logic [ACC_WIDTH-1:0]    sum_o
);
    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0]    prod [N];
    logic signed [ACC_WIDTH-1:0] acc;

    for (genvar n = 0; n < N; n++) begin : g_mul
        assign prod[n] = $signed(w_row_i[n*DATA_WIDTH +: DATA_WIDTH])
                       * $signed(x_vec_i[n*DATA_WIDTH +: DATA_WIDTH]);
    end

    // The cast sign-extends or truncates the product to the accumulator width
    always_comb begin
        acc = $signed(bias_i);
        for (int n = 0; n < N; n++) begin
            acc = acc + ACC_WIDTH'(prod[n]);
        end
    end

    assign sum_o = acc;
endmodule

// File: rtl/fcn_matrix_mult.sv
// Fully-connected layer core: M parallel dot products, one register stage.
// Output vector holds its last value while in_valid is low.
module fcn_matrix_mult
    import fcn_matrix_mult_pkg::*;
#(
    parameter int M          = FCN_M,
    parameter int N          = FCN_N,
    parameter int DATA_WIDTH = FCN_DW,
    parameter int ACC_WIDTH  = FCN_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH*N-1:0]   in_vec_flat,
    input  logic [DATA_WIDTH*M*N-1:0] weight_flat,
    input  logic [ACC_WIDTH*M-1:0]    bias_flat,
    output logic                      out_valid,
    output logic [ACC_WIDTH*M-1:0]    out_vec_flat
);
    logic [ACC_WIDTH*M-1:0] sum_flat;
    logic [ACC_WIDTH*M-1:0] out_vec_d, out_vec_q;
    logic                   out_valid_d, out_valid_q;

    for (genvar m = 0; m < M; m++) begin : g_row
        fcn_dot_product #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_dot (
            .w_row_i (weight_flat[m*N*DATA_WIDTH +: N*DATA_WIDTH]),
            .x_vec_i (in_vec_flat),
            .bias_i  (bias_flat[m*ACC_WIDTH +: ACC_WIDTH]),
            .sum_o   (sum_flat[m*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    always_comb begin
        out_valid_d = in_valid;
        out_vec_d   = in_valid ? sum_flat : out_vec_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_vec_flat = out_vec_q;
endmodule

// File: tb/tb_fcn_matrix_mult.sv
// Directed and random checks of the FC core at 2x3 and 4x16 sizes.
// Expected values come from integer arithmetic reduced modulo 2^16.
module tb_fcn_matrix_mult;
    localparam int M1 = 2;
    localparam int N1 = 3;
    localparam int M2 = 4;
    localparam int N2 = 16;
    localparam int DW = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;

    logic [DW*N1-1:0]    xa;
    logic [DW*M1*N1-1:0] wa;
    logic [AW*M1-1:0]    ba;
    logic                va;
    logic [AW*M1-1:0]    ya;

    logic [DW*N2-1:0]    xb;
    logic [DW*M2*N2-1:0] wb;
    logic [AW*M2-1:0]    bb;
    logic                vb;
    logic [AW*M2-1:0]    yb;

    int xv [N2];
    int wv [M2][N2];
    int bv [M2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW*M1-1:0] exp_a;
    logic [AW*M2-1:0] exp_b;
    logic             exp_v;

    always #5 clk = ~clk;

    fcn_matrix_mult #(.M(M1), .N(N1), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_vec_flat  (xa),
        .weight_flat  (wa),
        .bias_flat    (ba),
        .out_valid    (va),
        .out_vec_flat (ya)
    );

    fcn_matrix_mult #(.M(M2), .N(N2), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_vec_flat  (xb),
        .weight_flat  (wb),
        .bias_flat    (bb),
        .out_valid    (vb),
        .out_vec_flat (yb)
    );

    task automatic chk(input string tag, input logic [AW*M2-1:0] obs,
                       input logic [AW*M2-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void pack();
        for (int n = 0; n < N1; n++) xa[n*DW +: DW] = xv[n][DW-1:0];
        for (int m = 0; m < M1; m++) begin
            ba[m*AW +: AW] = bv[m][AW-1:0];
            for (int n = 0; n < N1; n++)
                wa[(m*N1+n)*DW +: DW] = wv[m][n][DW-1:0];
        end
        for (int n = 0; n < N2; n++) xb[n*DW +: DW] = xv[n][DW-1:0];
        for (int m = 0; m < M2; m++) begin
            bb[m*AW +: AW] = bv[m][AW-1:0];
            for (int n = 0; n < N2; n++)
                wb[(m*N2+n)*DW +: DW] = wv[m][n][DW-1:0];
        end
    endfunction

    function automatic logic [AW*M1-1:0] model_a();
        logic [AW*M1-1:0] r;
        for (int m = 0; m < M1; m++) begin
            int s = bv[m];
            for (int n = 0; n < N1; n++) s += wv[m][n] * xv[n];
            r[m*AW +: AW] = s[AW-1:0];
        end
        return r;
    endfunction

    function automatic logic [AW*M2-1:0] model_b();
        logic [AW*M2-1:0] r;
        for (int m = 0; m < M2; m++) begin
            int s = bv[m];
            for (int n = 0; n < N2; n++) s += wv[m][n] * xv[n];
            r[m*AW +: AW] = s[AW-1:0];
        end
        return r;
    endfunction

    function automatic void clear_ops();
        for (int n = 0; n < N2; n++) xv[n] = 0;
        for (int m = 0; m < M2; m++) begin
            bv[m] = 0;
            for (int n = 0; n < N2; n++) wv[m][n] = 0;
        end
    endfunction

    function automatic void set_case1();
        clear_ops();
        xv[0] = 1;  xv[1] = 2;  xv[2] = 3;
        wv[0][0] = 1; wv[0][1] = 0; wv[0][2] = -1;
        wv[1][0] = 2; wv[1][1] = 1; wv[1][2] = 1;
        bv[0] = 1;  bv[1] = -2;
        pack();
    endfunction

    function automatic void randomize_ops();
        for (int n = 0; n < N2; n++) xv[n] = $urandom_range(0, 255) - 128;
        for (int m = 0; m < M2; m++) begin
            bv[m] = $urandom_range(0, 65535) - 32768;
            for (int n = 0; n < N2; n++)
                wv[m][n] = $urandom_range(0, 255) - 128;
        end
        pack();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        clear_ops();
        pack();
        tick();
        tick();
        chk("reset_valid_a", 64'(va), 64'(0));
        chk("reset_out_a", 64'(ya), 64'(0));
        chk("reset_valid_b", 64'(vb), 64'(0));
        chk("reset_out_b", 64'(yb), 64'(0));

        // Case 1: basic single transaction
        rst = 1'b0;
        set_case1();
        in_valid = 1'b1;
        tick();
        chk("basic_valid", 64'(va), 64'(1));
        chk("basic_out", 64'(ya), 64'({16'd5, 16'hFFFF}));
        in_valid = 1'b0;
        randomize_ops();
        tick();
        chk("idle_valid", 64'(va), 64'(0));
        chk("idle_hold", 64'(ya), 64'({16'd5, 16'hFFFF}));

        // Case 2: reset wins over in_valid
        rst = 1'b1;
        set_case1();
        in_valid = 1'b1;
        tick();
        chk("rst_pri_valid", 64'(va), 64'(0));
        chk("rst_pri_out", 64'(ya), 64'(0));
        rst = 1'b0;
        tick();
        chk("after_rst_valid", 64'(va), 64'(1));
        chk("after_rst_out", 64'(ya), 64'({16'd5, 16'hFFFF}));

        // Case 3: most-negative operands and wrap
        clear_ops();
        for (int n = 0; n < N1; n++) begin
            xv[n] = -128;
            wv[0][n] = -128;
            wv[1][n] = 127;
        end
        pack();
        tick();
        chk("extreme_valid", 64'(va), 64'(1));
        chk("extreme_out", 64'(ya), 64'({16'h4180, 16'hC000}));

        // Case 4: back-to-back streaming
        set_case1();
        tick();
        chk("stream0_valid", 64'(va), 64'(1));
        chk("stream0_out", 64'(ya), 64'({16'd5, 16'hFFFF}));
        clear_ops();
        bv[0] = 7;
        bv[1] = -7;
        pack();
        tick();
        chk("stream1_valid", 64'(va), 64'(1));
        chk("stream1_out", 64'(ya), 64'({16'hFFF9, 16'h0007}));

        // Case 5: random stream, both sizes, from a clean reset
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        exp_a = '0;
        exp_b = '0;
        exp_v = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            randomize_ops();
            in_valid = ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                exp_a = model_a();
                exp_b = model_b();
            end
            exp_v = in_valid;
            tick();
            chk("rand_valid_a", 64'(va), 64'(exp_v));
            chk("rand_out_a", 64'(ya), 64'(exp_a));
            chk("rand_valid_b", 64'(vb), 64'(exp_v));
            chk("rand_out_b", yb, exp_b);
        end
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
